// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter controller for instruction fetch.
// Advances the PC every cycle, redirects on a taken branch (with a single
// squash cycle for the wrong-path instruction), and parks in HALT on request.
// Optional macro FETCH_SEQ_BR_STATS_EN enables the taken-branch counter;
// when undefined, taken_count is tied to zero.
//
// Handshake: there is no valid/ready pair here. stall is a plain hold
// qualifier. When stall=1, the PC and the state do not move, while cycle_count
// still counts. The branch unit's taken/target pair is consumed only on a
// non-stalled RUN cycle.
module fetch_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             squash,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cyc_inc;

    // Saturating increment of the busy-cycle counter
    always_comb begin
        cyc_inc = cyc_q;
        if (cyc_q != '1) cyc_inc = cyc_q + CNT_W'(1);
    end

    // State, PC and cycle counter registers; reset is asynchronous
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state, next-PC and counter logic; halt outranks a simultaneous branch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_inc;
                if (!stall) begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (branch_taken) begin
                        state_d = FLUSH;
                        pc_d    = branch_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            FLUSH: begin
                // Branch/halt here belong to the squashed instruction: ignored
                cyc_d = cyc_inc;
                if (!stall) begin
                    state_d = RUN;
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded straight from the state register
    assign fetch_en    = (state_q == RUN) || (state_q == FLUSH);
    assign squash      = (state_q == FLUSH);
    assign done        = (state_q == HALT);
    assign pc          = pc_q;
    assign cycle_count = cyc_q;

`ifdef FETCH_SEQ_BR_STATS_EN
    logic             redirect;
    logic             start_accept;
    logic [CNT_W-1:0] taken_q;

    assign redirect     = (state_q == RUN) && !stall && !halt_req && branch_taken;
    assign start_accept = ((state_q == IDLE) || (state_q == HALT)) && start;

    // Saturating count of accepted redirects, cleared on start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q <= '0;
        end else if (start_accept) begin
            taken_q <= '0;
        end else if (redirect && (taken_q != '1)) begin
            taken_q <= taken_q + CNT_W'(1);
        end
    end

    assign taken_count = taken_q;
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Expected PCs go into exp_q when the
// stimulus is driven and are popped when the DUT output is sampled.
module tb_fetch_sequencer;

    localparam int PC_W       = 10;
    localparam int CNT_W      = 16;
    localparam int START_ADDR = 0;
`ifdef FETCH_SEQ_BR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             start, stall, branch_taken, halt_req;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  pc;
    logic             fetch_en, squash, done;
    logic [CNT_W-1:0] cycle_count, taken_count;

    fetch_sequencer #(
        .PC_W      (PC_W),
        .START_ADDR(START_ADDR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .squash       (squash),
        .done         (done),
        .cycle_count  (cycle_count),
        .taken_count  (taken_count)
    );

    // ---------------- scoreboard state ----------------
    int               checks   = 0;
    int               failures = 0;
    logic [PC_W-1:0]  exp_q[$];
    logic [PC_W-1:0]  exp_pc;
    logic [CNT_W-1:0] exp_cyc   = '0;
    logic [CNT_W-1:0] exp_taken = '0;

    function automatic logic [CNT_W-1:0] exp_tc();
        return STATS ? exp_taken : '0;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 2ns after the rising edge.
    // active: DUT was in RUN/FLUSH before this edge, so the cycle counter moves.
    task automatic tick(input bit active);
        @(posedge clk);
        #2;
        if (active && exp_cyc != '1) exp_cyc = exp_cyc + CNT_W'(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; halt_req = 1'b0; branch_target = '0;
        repeat (2) @(posedge clk);
        #2;
        exp_cyc = '0; exp_taken = '0;
        checks++; if (pc !== START_PC) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, START_PC); end
        checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL reset_fetch_en: got %b expected 0", fetch_en); end
        checks++; if (squash !== 1'b0) begin failures++; $display("FAIL reset_squash: got %b expected 0", squash); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (cycle_count !== '0) begin failures++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
        checks++; if (taken_count !== '0) begin failures++; $display("FAIL reset_taken_count: got %0d expected 0", taken_count); end
        reset = 1'b0;
        tick(0);
        checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL idle_fetch_en: got %b expected 0", fetch_en); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i <= 5; i++) exp_q.push_back(START_PC + PC_W'(i));
        start = 1'b1;
        tick(0);
        start = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL seq_pc_start: got %h expected %h", pc, exp_pc); end
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
            checks++; if (fetch_en !== 1'b1 || squash !== 1'b0) begin failures++; $display("FAIL seq_ctrl[%0d]: got fetch_en=%b squash=%b expected 1/0", i, fetch_en, squash); end
        end
        checks++; if (cycle_count !== CNT_W'(5)) begin failures++; $display("FAIL seq_cycle_count: got %0d expected 5", cycle_count); end
    endtask

    task automatic test_branch();
        exp_q.push_back(10'h006); exp_q.push_back(10'h007);
        for (int i = 0; i < 2; i++) begin
            tick(1);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc) begin failures++; $display("FAIL br_lead_pc: got %h expected %h", pc, exp_pc); end
        end
        branch_taken = 1'b1; branch_target = 10'h040;
        exp_q.push_back(10'h040);
        tick(1);
        exp_taken++;
        branch_taken = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL br_target_pc: got %h expected %h", pc, exp_pc); end
        checks++; if (squash !== 1'b1 || fetch_en !== 1'b1) begin failures++; $display("FAIL br_squash_on: got squash=%b fetch_en=%b expected 1/1", squash, fetch_en); end
        exp_q.push_back(10'h041);
        tick(1);
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL br_after_pc: got %h expected %h", pc, exp_pc); end
        checks++; if (squash !== 1'b0) begin failures++; $display("FAIL br_squash_off: got %b expected 0", squash); end
        checks++; if (taken_count !== exp_tc()) begin failures++; $display("FAIL br_taken_count: got %0d expected %0d", taken_count, exp_tc()); end
    endtask

    task automatic test_stall_branch();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 10'h100;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(10'h041);
            tick(1);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc || squash !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d]: got pc=%h squash=%b expected %h/0", i, pc, squash, exp_pc); end
        end
        checks++; if (cycle_count !== exp_cyc) begin failures++; $display("FAIL stall_cycle_count: got %0d expected %0d", cycle_count, exp_cyc); end
        stall = 1'b0;
        exp_q.push_back(10'h100);
        tick(1);
        exp_taken++;
        branch_taken = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc || squash !== 1'b1) begin failures++; $display("FAIL stall_redirect: got pc=%h squash=%b expected %h/1", pc, squash, exp_pc); end
        // Stall while in FLUSH: PC holds and squash stays asserted
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(10'h100);
            tick(1);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc || squash !== 1'b1) begin failures++; $display("FAIL flush_stall[%0d]: got pc=%h squash=%b expected %h/1", i, pc, squash, exp_pc); end
        end
        stall = 1'b0;
        exp_q.push_back(10'h101);
        tick(1);
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc || squash !== 1'b0) begin failures++; $display("FAIL flush_release: got pc=%h squash=%b expected %h/0", pc, squash, exp_pc); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 10'h3FF;
        exp_q.push_back(10'h3FF);
        tick(1);
        exp_taken++;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc || squash !== 1'b1) begin failures++; $display("FAIL wrap_top: got pc=%h squash=%b expected %h/1", pc, squash, exp_pc); end
        // Wrong-path branch and halt during FLUSH must be ignored
        branch_target = 10'h123; halt_req = 1'b1;
        exp_q.push_back(10'h000);
        tick(1);
        branch_taken = 1'b0; halt_req = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL wrap_zero: got %h expected %h", pc, exp_pc); end
        checks++; if (done !== 1'b0 || fetch_en !== 1'b1 || squash !== 1'b0) begin failures++; $display("FAIL wrap_flush_ignore: got done=%b fetch_en=%b squash=%b expected 0/1/0", done, fetch_en, squash); end
        exp_q.push_back(10'h001);
        tick(1);
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL wrap_next: got %h expected %h", pc, exp_pc); end
        checks++; if (taken_count !== exp_tc()) begin failures++; $display("FAIL wrap_taken_count: got %0d expected %0d", taken_count, exp_tc()); end
    endtask

    task automatic test_halt();
        branch_taken = 1'b1; branch_target = 10'h00F;
        exp_q.push_back(10'h00F); exp_q.push_back(10'h010);
        tick(1);
        exp_taken++;
        branch_taken = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL halt_lead0: got %h expected %h", pc, exp_pc); end
        tick(1);
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL halt_lead1: got %h expected %h", pc, exp_pc); end
        halt_req = 1'b1; branch_taken = 1'b1; branch_target = 10'h200;
        exp_q.push_back(10'h010);
        tick(1);
        halt_req = 1'b0; branch_taken = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL halt_pc: got %h expected %h", pc, exp_pc); end
        checks++; if (done !== 1'b1 || fetch_en !== 1'b0 || squash !== 1'b0) begin failures++; $display("FAIL halt_ctrl: got done=%b fetch_en=%b squash=%b expected 1/0/0", done, fetch_en, squash); end
        checks++; if (taken_count !== exp_tc()) begin failures++; $display("FAIL halt_taken_count: got %0d expected %0d", taken_count, exp_tc()); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(10'h010);
            tick(0);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc || done !== 1'b1) begin failures++; $display("FAIL halt_frozen[%0d]: got pc=%h done=%b expected %h/1", i, pc, done, exp_pc); end
        end
        checks++; if (cycle_count !== exp_cyc) begin failures++; $display("FAIL halt_cycle_hold: got %0d expected %0d", cycle_count, exp_cyc); end
        start = 1'b1;
        exp_q.push_back(START_PC);
        tick(0);
        exp_cyc = '0; exp_taken = '0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL restart_pc: got %h expected %h", pc, exp_pc); end
        checks++; if (done !== 1'b0 || fetch_en !== 1'b1) begin failures++; $display("FAIL restart_ctrl: got done=%b fetch_en=%b expected 0/1", done, fetch_en); end
        checks++; if (cycle_count !== '0) begin failures++; $display("FAIL restart_cycle_count: got %0d expected 0", cycle_count); end
        checks++; if (taken_count !== '0) begin failures++; $display("FAIL restart_taken_count: got %0d expected 0", taken_count); end
        // start held while running has no effect
        exp_q.push_back(START_PC + PC_W'(1));
        tick(1);
        start = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL start_in_run: got %h expected %h", pc, exp_pc); end
    endtask

    task automatic test_reset_mid_flush();
        branch_taken = 1'b1; branch_target = 10'h2AA;
        exp_q.push_back(10'h2AA);
        tick(1);
        branch_taken = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc || squash !== 1'b1) begin failures++; $display("FAIL mid_flush_entry: got pc=%h squash=%b expected %h/1", pc, squash, exp_pc); end
        #1 reset = 1'b1;
        #1;
        exp_cyc = '0; exp_taken = '0;
        checks++; if (squash !== 1'b0 || fetch_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_ctrl: got squash=%b fetch_en=%b done=%b expected 0/0/0", squash, fetch_en, done); end
        checks++; if (pc !== START_PC) begin failures++; $display("FAIL async_reset_pc: got %h expected %h", pc, START_PC); end
        checks++; if (cycle_count !== '0) begin failures++; $display("FAIL async_reset_cycle: got %0d expected 0", cycle_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(START_PC);
            tick(0);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc || fetch_en !== 1'b0) begin failures++; $display("FAIL post_reset_idle[%0d]: got pc=%h fetch_en=%b expected %h/0", i, pc, fetch_en, exp_pc); end
        end
        start = 1'b1;
        exp_q.push_back(START_PC);
        tick(0);
        start = 1'b0;
        exp_pc = exp_q.pop_front();
        checks++; if (pc !== exp_pc || fetch_en !== 1'b1) begin failures++; $display("FAIL post_reset_start: got pc=%h fetch_en=%b expected %h/1", pc, fetch_en, exp_pc); end
    endtask

    // Random stall/branch traffic checked against a small reference model
    task automatic test_random();
        logic [PC_W-1:0] mpc;
        bit              mflush;
        mpc = START_PC;
        mflush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = PC_W'($urandom_range(0, (1 << PC_W) - 1));
            halt_req      = mflush ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (!stall) begin
                if (mflush) begin
                    mpc = mpc + PC_W'(1);
                    mflush = 1'b0;
                end else if (branch_taken) begin
                    mpc = branch_target;
                    mflush = 1'b1;
                    exp_taken++;
                end else begin
                    mpc = mpc + PC_W'(1);
                end
            end
            exp_q.push_back(mpc);
            tick(1);
            exp_pc = exp_q.pop_front();
            checks++; if (pc !== exp_pc || squash !== mflush) begin failures++; $display("FAIL rand[%0d]: got pc=%h squash=%b expected %h/%b", i, pc, squash, exp_pc, mflush); end
        end
        stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        checks++; if (cycle_count !== exp_cyc) begin failures++; $display("FAIL rand_cycle_count: got %0d expected %0d", cycle_count, exp_cyc); end
        checks++; if (taken_count !== exp_tc()) begin failures++; $display("FAIL rand_taken_count: got %0d expected %0d", taken_count, exp_tc()); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_branch();
        test_wrap();
        test_halt();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller that sequences instruction fetch around the branch unit.
- Holds the PC and advances it each cycle.
- Redirects the PC on a taken branch, squashes the wrong-path instruction already in flight, and stops on a halt request.
- Sits between instruction memory and decode; consumes the branch unit's taken/target outputs.

Parameters:
- PC_W, 10, PC and branch-target width.
- START_ADDR, 0, PC value loaded on reset and on start.
- CNT_W, 16, width of cycle_count and taken_count.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  begin execution from START_ADDR (honoured in IDLE and HALT).
- stall  in  1  freeze PC and state this cycle.
- branch_taken  in  1  branch unit's decision for the instruction in decode.
- branch_target  in  PC_W  redirect address, valid when branch_taken=1.
- halt_req  in  1  decoded halt instruction.
- pc  out  PC_W  current fetch address.
- fetch_en  out  1  instruction-memory read enable.
- squash  out  1  decode must discard its instruction this cycle.
- done  out  1  program halted.
- cycle_count  out  CNT_W  cycles spent in RUN/FLUSH.
- taken_count  out  CNT_W  taken-branch count (see optional feature).

Behaviour:
- States: IDLE, RUN, FLUSH, HALT. Moore outputs, registered state.
- Reset (async, any time, including mid-branch): state=IDLE, pc=START_ADDR, cycle_count=0, taken_count=0. Takes effect without a clock edge.
- Output reset values: fetch_en=0, squash=0, done=0.
- IDLE:
  - fetch_en=0, squash=0, done=0.
  - start=1 → RUN, pc=START_ADDR, cycle_count cleared.
- RUN:
  - fetch_en=1.
  - stall=1 → pc/state held; branch_taken and halt_req ignored.
  - Otherwise, in priority order:
    - halt_req=1 → HALT, pc held.
    - branch_taken=1 → pc<=branch_target, state FLUSH.
    - Else pc<=pc+1.
- FLUSH (one non-stalled cycle):
  - squash=1, fetch_en=1.
  - branch_taken and halt_req ignored; they come from the squashed wrong-path instruction.
  - stall=1 → held in FLUSH, squash stays 1.
  - Otherwise pc<=pc+1, → RUN.
- HALT:
  - done=1, fetch_en=0, pc frozen.
  - start=1 → RUN, pc=START_ADDR, done clears next cycle, cycle_count cleared.
- start is ignored in RUN/FLUSH.
- PC arithmetic: modulo 2^PC_W. pc=2^PC_W-1 increments to 0; no flag.
- Branch to own address: legal; pc reloads same value and FLUSH still occurs.
- Redirect latency: branch_taken sampled at edge N → pc=target after N, squash=1 during the N→N+1 cycle.
- cycle_count:
  - Increments every clock in RUN or FLUSH, stalled cycles included.
  - Saturates at all-ones; holds in HALT/IDLE.
- Simultaneous branch_taken and halt_req in RUN: halt wins; no redirect, taken_count unchanged.

Optional Feature:
- Macro: FETCH_SEQ_BR_STATS_EN.
- Defined: taken_count increments once per accepted redirect (RUN, stall=0, halt_req=0, branch_taken=1). It saturates at all-ones, is cleared by reset and by start, and holds otherwise.
- Undefined: no counter logic is synthesised; taken_count is tied to 0. All other behaviour is identical.

Test Plan:
- Reset then start=1, no stall, 5 cycles → pc 0,1,2,3,4,5; fetch_en=1; squash=0; cycle_count=5.
- At pc=7, branch_taken=1, target=0x040 → next pc=0x040, squash=1 for exactly one cycle, then pc=0x041. With macro defined, taken_count=1.
- stall=1 for 3 cycles in RUN with branch_taken=1 held, then released → pc unchanged for 3 cycles, redirect on first unstalled edge. cycle_count advances by 3 during the stall.
- Branch to 0x3FF, then run → pc 0x3FF then 0x000 (wrap). halt_req and branch_taken in the FLUSH cycle are ignored; state returns to RUN.
- halt_req=1 and branch_taken=1 together at pc=0x010 → HALT, done=1, fetch_en=0, pc=0x010. A later start=1 → pc=START_ADDR, RUN, done=0.
- Assert reset asynchronously mid-FLUSH (between edges) → squash, fetch_en and done drop to 0 and pc=START_ADDR immediately; IDLE until start.
